// File: rtl/instruction_fetch_stage_pkg.sv
// Shared fetch-stage definitions: FSM state encodings, instruction width in bytes, default reset PC.
// Pure constants, no logic.
package instruction_fetch_stage_pkg;

    localparam logic [1:0]  S_BOOT = 2'd0;
    localparam logic [1:0]  S_RUN  = 2'd1;
    localparam logic [1:0]  S_HALT = 2'd2;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_stage_pc_reg.sv
// Program counter register with next-PC mux (reset / redirect / increment / hold).
// Redirect beats increment; the new PC is visible the cycle after the request.
module instruction_fetch_stage_pc_reg
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] PC_STEP  = 32'(INSTR_BYTES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] target_i,
    input  logic        incr_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = target_i;
        end else if (incr_i) begin
            // Wraps modulo 2^32 with no flag.
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, reads the combinational ROM and holds the word in a valid/ready IF/ID register.
// PC-to-output latency 1 cycle; output held while !outReady. Define FETCH_MISALIGN_TRAP_EN to halt on misaligned redirects.
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] PC_STEP  = 32'(INSTR_BYTES)
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] romAddress,
    input  logic [31:0] romData,
    input  logic        redirectValid,
    input  logic [31:0] redirectTarget,
    input  logic        haltReq,
    output logic        outValid,
    input  logic        outReady,
    output logic [31:0] outPc,
    output logic [31:0] outInstruction,
    output logic [31:0] outPcPlus4
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetchMisaligned,
    output logic [31:0] misalignAddr
`endif
);

    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [31:0] pc;
    logic        advance;
    logic        capture;
    logic        trap_redirect;

    logic        out_vld_q;
    logic        out_vld_d;
    logic [31:0] out_pc_q;
    logic [31:0] out_instr_q;
    logic [31:0] out_pc_plus4_q;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misaligned_q;
    logic [31:0] misalign_addr_q;

    assign trap_redirect = redirectValid && (redirectTarget[1:0] != 2'b00);
`else
    assign trap_redirect = 1'b0;
`endif

    assign advance = !out_vld_q || outReady;
    assign capture = (state_q == S_RUN) && advance && !redirectValid;

    instruction_fetch_stage_pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .redirect_i (redirectValid),
        .target_i   (redirectTarget),
        .incr_i     (capture),
        .pc_o       (pc)
    );

    assign romAddress = pc;

    // Redirect outranks halt: a halt request seen alongside a redirect is re-sampled next cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                if (!redirectValid && haltReq) begin
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                if (redirectValid) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_BOOT;
        endcase
        if (trap_redirect) begin
            state_d = S_HALT;
        end
    end

    // Flush on redirect; otherwise a handed-off word with no replacement drops valid but keeps its data.
    always_comb begin
        out_vld_d = out_vld_q;
        if (redirectValid) begin
            out_vld_d = 1'b0;
        end else if (capture) begin
            out_vld_d = 1'b1;
        end else if (out_vld_q && outReady) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_BOOT;
            out_vld_q      <= 1'b0;
            out_pc_q       <= 32'h0;
            out_instr_q    <= 32'h0;
            out_pc_plus4_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            out_vld_q <= out_vld_d;
            if (capture) begin
                out_pc_q       <= pc;
                out_instr_q    <= romData;
                out_pc_plus4_q <= pc + PC_STEP;
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Sticky until reset or the next redirect, which re-evaluates alignment.
    always_ff @(posedge clk) begin
        if (rst) begin
            misaligned_q    <= 1'b0;
            misalign_addr_q <= 32'h0;
        end else if (redirectValid) begin
            misaligned_q    <= trap_redirect;
            misalign_addr_q <= trap_redirect ? redirectTarget : 32'h0;
        end
    end

    assign fetchMisaligned = misaligned_q;
    assign misalignAddr    = misalign_addr_q;
`endif

    assign outValid       = out_vld_q;
    assign outPc          = out_pc_q;
    assign outInstruction = out_instr_q;
    assign outPcPlus4     = out_pc_plus4_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with a behavioural combinational ROM.
module tb_instruction_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] romAddress;
    logic [31:0] romData;
    logic        redirectValid;
    logic [31:0] redirectTarget;
    logic        haltReq;
    logic        outValid;
    logic        outReady;
    logic [31:0] outPc;
    logic [31:0] outInstruction;
    logic [31:0] outPcPlus4;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetchMisaligned;
    logic [31:0] misalignAddr;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // ROM image: words 0..3 hold a NOP, everything above returns a tagged copy of its address.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a < 32'd16) ? 32'h0000_0013 : (32'hA000_0000 | a);
    endfunction

    assign romData = rom_word(romAddress);

    instruction_fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .romAddress     (romAddress),
        .romData        (romData),
        .redirectValid  (redirectValid),
        .redirectTarget (redirectTarget),
        .haltReq        (haltReq),
        .outValid       (outValid),
        .outReady       (outReady),
        .outPc          (outPc),
        .outInstruction (outInstruction),
        .outPcPlus4     (outPcPlus4)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetchMisaligned(fetchMisaligned),
        .misalignAddr   (misalignAddr)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic vld, input logic [31:0] pc,
                           input logic [31:0] instr, input logic [31:0] pc4);
        chk({tag, ".valid"}, {31'h0, outValid}, {31'h0, vld});
        chk({tag, ".pc"}, outPc, pc);
        chk({tag, ".instr"}, outInstruction, instr);
        chk({tag, ".pc4"}, outPcPlus4, pc4);
    endtask

    initial begin
        rst            = 1'b1;
        outReady       = 1'b1;
        redirectValid  = 1'b0;
        redirectTarget = 32'h0;
        haltReq        = 1'b0;
        step();
        step();
        chk_out("reset", 1'b0, 32'h0, 32'h0, 32'h0);
        chk("reset.rom", romAddress, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("reset.mis", {31'h0, fetchMisaligned}, 32'h0);
`endif

        // Boot cycle: no capture.
        rst = 1'b0;
        step();
        chk("boot.valid", {31'h0, outValid}, 32'h0);
        chk("boot.rom", romAddress, 32'h0);
        step();
        chk_out("first", 1'b1, 32'h0, 32'h13, 32'h4);
        chk("first.rom", romAddress, 32'h4);
        step();
        chk("run1.pc", outPc, 32'h4);
        step();
        chk_out("run2", 1'b1, 32'h8, 32'h13, 32'hC);
        chk("run2.rom", romAddress, 32'hC);

        // Backpressure for three cycles at outPc=8.
        outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("stall", 1'b1, 32'h8, 32'h13, 32'hC);
            chk("stall.rom", romAddress, 32'hC);
        end
        outReady = 1'b1;
        step();
        chk_out("release", 1'b1, 32'hC, 32'h13, 32'h10);

        // Redirect flush while stalled.
        outReady       = 1'b0;
        redirectValid  = 1'b1;
        redirectTarget = 32'h40;
        step();
        chk("flush.valid", {31'h0, outValid}, 32'h0);
        chk("flush.rom", romAddress, 32'h40);
        redirectValid = 1'b0;
        outReady      = 1'b1;
        step();
        chk_out("target", 1'b1, 32'h40, 32'hA000_0040, 32'h44);

        // Halt: the current fetch completes, then the PC freezes.
        haltReq = 1'b1;
        step();
        chk_out("halt.last", 1'b1, 32'h44, 32'hA000_0044, 32'h48);
        chk("halt.rom", romAddress, 32'h48);
        haltReq = 1'b0;
        step();
        chk("halt.drain", {31'h0, outValid}, 32'h0);
        step();
        step();
        chk("halt.hold.rom", romAddress, 32'h48);
        chk("halt.hold.pc", outPc, 32'h44);
        chk("halt.hold.valid", {31'h0, outValid}, 32'h0);

        // Resume via redirect.
        redirectValid  = 1'b1;
        redirectTarget = 32'h20;
        step();
        chk("resume.valid", {31'h0, outValid}, 32'h0);
        chk("resume.rom", romAddress, 32'h20);
        redirectValid = 1'b0;
        step();
        chk_out("resume", 1'b1, 32'h20, 32'hA000_0020, 32'h24);

        // Address wrap.
        redirectValid  = 1'b1;
        redirectTarget = 32'hFFFF_FFFC;
        step();
        chk("wrap.rom", romAddress, 32'hFFFF_FFFC);
        redirectValid = 1'b0;
        step();
        chk_out("wrap.top", 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0);
        chk("wrap.rom0", romAddress, 32'h0);
        step();
        chk_out("wrap.zero", 1'b1, 32'h0, 32'h13, 32'h4);

        // Redirect together with halt: redirect first, halt the cycle after.
        redirectValid  = 1'b1;
        redirectTarget = 32'h80;
        haltReq        = 1'b1;
        step();
        chk("rh.valid", {31'h0, outValid}, 32'h0);
        chk("rh.rom", romAddress, 32'h80);
        redirectValid = 1'b0;
        step();
        chk_out("rh.cap", 1'b1, 32'h80, 32'hA000_0080, 32'h84);
        haltReq = 1'b0;
        step();
        chk("rh.halt.valid", {31'h0, outValid}, 32'h0);
        chk("rh.halt.rom", romAddress, 32'h84);

        // Reset in the middle of backpressure.
        redirectValid  = 1'b1;
        redirectTarget = 32'h100;
        step();
        redirectValid = 1'b0;
        step();
        chk("mr.cap", outPc, 32'h100);
        outReady = 1'b0;
        step();
        chk_out("mr.stall", 1'b1, 32'h100, 32'hA000_0100, 32'h104);
        rst = 1'b1;
        step();
        chk_out("mr.reset", 1'b0, 32'h0, 32'h0, 32'h0);
        chk("mr.rom", romAddress, 32'h0);
        rst      = 1'b0;
        outReady = 1'b1;
        step();
        chk("mr.boot", {31'h0, outValid}, 32'h0);
        step();
        chk_out("mr.run", 1'b1, 32'h0, 32'h13, 32'h4);

        // Misaligned redirect.
        redirectValid  = 1'b1;
        redirectTarget = 32'h42;
        step();
        redirectValid = 1'b0;
        chk("mis.rom", romAddress, 32'h42);
        chk("mis.valid", {31'h0, outValid}, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis.flag", {31'h0, fetchMisaligned}, 32'h1);
        chk("mis.addr", misalignAddr, 32'h42);
        step();
        chk("mis.halt.rom", romAddress, 32'h42);
        chk("mis.halt.valid", {31'h0, outValid}, 32'h0);
        redirectValid  = 1'b1;
        redirectTarget = 32'h10;
        step();
        redirectValid = 1'b0;
        chk("mis.clear", {31'h0, fetchMisaligned}, 32'h0);
        chk("mis.clear.addr", misalignAddr, 32'h0);
        step();
        chk_out("mis.resume", 1'b1, 32'h10, 32'hA000_0010, 32'h14);
`else
        step();
        chk_out("mis.pass", 1'b1, 32'h42, 32'hA000_0042, 32'h46);
        chk("mis.pass.rom", romAddress, 32'h46);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
